// File: rtl/alu_seq_exec.sv
// -----------------------------------------------------------------------------
// alu_seq_exec
//   Multi-cycle integer execute unit. One request (ALUControl, SrcA, SrcB) is
//   taken over a valid/ready handshake. Its result is returned over a second
//   valid/ready handshake. The unit holds one operation at a time.
//
//   Shifts take one cycle per bit of shift amount. Defining ALU_BARREL_SHIFT_EN
//   changes this: shifts then finish in one cycle, like every other operation.
//
// Ports
//   clk, reset             rising-edge clock, synchronous active-high reset
//   in_valid / in_ready    request handshake (in_ready only in IDLE, out of reset)
//   ALUControl             4-bit operation code
//   SrcA, SrcB             operands (SrcA = PC for auipc, shamt = SrcB[SHAMT_W-1:0])
//   out_valid / out_ready  result handshake
//   ALUResult, Zero        registered result and result==0 flag
//   Illegal                registered: the captured code was unsupported
// -----------------------------------------------------------------------------
module alu_seq_exec #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      ALUControl,
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] ALUResult,
    output logic            Zero,
    output logic            Illegal
);

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0010;
    localparam logic [3:0] OP_OR    = 4'b0011;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_SLT   = 4'b0101;
    localparam logic [3:0] OP_SLTU  = 4'b0110;
    localparam logic [3:0] OP_AUIPC = 4'b1000;
    localparam logic [3:0] OP_SLL   = 4'b1010;
    localparam logic [3:0] OP_SRA   = 4'b1011;
    localparam logic [3:0] OP_SRL   = 4'b1100;
    localparam logic [3:0] OP_LUI   = 4'b1101;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t               state;
    logic [SHAMT_W-1:0]   cnt;        // shift bits still to apply
    logic [3:0]           op_q;       // shift kind held during SHIFT
    logic [XLEN-1:0]      comb_res;
    logic                 comb_ill;
    logic                 is_shift;
    logic                 go_iter;
    logic [SHAMT_W-1:0]   shamt;
    logic [XLEN-1:0]      next_shift;

    assign shamt    = SrcB[SHAMT_W-1:0];
    assign is_shift = (ALUControl == OP_SLL) || (ALUControl == OP_SRA) ||
                      (ALUControl == OP_SRL);

`ifdef ALU_BARREL_SHIFT_EN
    assign go_iter = 1'b0;
`else
    // A zero-length shift is just a copy of SrcA. It takes the single-cycle path.
    assign go_iter = is_shift && (shamt != '0);
`endif

    assign in_ready  = (state == S_IDLE) && !reset;
    assign out_valid = (state == S_DONE);

    // Single-bit step of the iterative shifter. ALUResult is the working value
    // while in SHIFT. Nobody observes it there because out_valid is low.
    function automatic logic [XLEN-1:0] shift1(input logic [3:0] op,
                                               input logic [XLEN-1:0] v);
        case (op)
            OP_SLL:  shift1 = {v[XLEN-2:0], 1'b0};
            OP_SRA:  shift1 = {v[XLEN-1], v[XLEN-1:1]};
            default: shift1 = {1'b0, v[XLEN-1:1]};
        endcase
    endfunction

    assign next_shift = shift1(op_q, ALUResult);

    always_comb begin
        comb_res = '0;
        comb_ill = 1'b0;
        case (ALUControl)
            OP_ADD:   comb_res = SrcA + SrcB;
            OP_SUB:   comb_res = SrcA - SrcB;
            OP_AND:   comb_res = SrcA & SrcB;
            OP_OR:    comb_res = SrcA | SrcB;
            OP_XOR:   comb_res = SrcA ^ SrcB;
            OP_SLT:   comb_res = {{(XLEN-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
            OP_SLTU:  comb_res = {{(XLEN-1){1'b0}}, (SrcA < SrcB)};
            OP_AUIPC: comb_res = SrcA + SrcB;
            OP_LUI:   comb_res = SrcB;
`ifdef ALU_BARREL_SHIFT_EN
            OP_SLL:   comb_res = SrcA << shamt;
            OP_SRA:   comb_res = XLEN'($signed(SrcA) >>> shamt);
            OP_SRL:   comb_res = SrcA >> shamt;
`else
            // Only reached on this path with shamt == 0.
            OP_SLL, OP_SRA, OP_SRL: comb_res = SrcA;
`endif
            default:  comb_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            ALUResult <= '0;
            Zero      <= 1'b0;
            Illegal   <= 1'b0;
            cnt       <= '0;
            op_q      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (go_iter) begin
                            ALUResult <= SrcA;
                            cnt       <= shamt;
                            op_q      <= ALUControl;
                            Zero      <= 1'b0;
                            Illegal   <= 1'b0;
                            state     <= S_SHIFT;
                        end else begin
                            ALUResult <= comb_res;
                            Zero      <= (comb_res == '0);
                            Illegal   <= comb_ill;
                            state     <= S_DONE;
                        end
                    end
                end
                S_SHIFT: begin
                    ALUResult <= next_shift;
                    cnt       <= cnt - 1'b1;
                    if (cnt == SHAMT_W'(1)) begin
                        Zero  <= (next_shift == '0);
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
